// File: rtl/window_load_controller.sv
// Window load controller: sequences the address generator through WIN line reads per
// window, buffers the rows into a WIN x WIN window and hands it to the downstream MAC.
module window_load_controller #(
    parameter int PIXEL_W = 8,
    parameter int WIN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIN*PIXEL_W-1:0]       mem_data,
    input  logic                         cout_addr_generator,
    input  logic                         window_ld_done,
    input  logic                         window_ready,
    output logic                         en_line_counter,
    output logic                         en_window_start_pos_counter,
    output logic [WIN*WIN*PIXEL_W-1:0]   window_data,
    output logic                         window_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int ROW_W = WIN * PIXEL_W;
    localparam int PTR_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WIN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        VALID,
        FINISH
    } state_t;

    state_t                      state_q, state_d;
    logic                        cap_q, cap_d;
    logic [PTR_W-1:0]            row_ptr_q, row_ptr_d;
    logic [WIN*WIN*PIXEL_W-1:0]  window_q, window_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cap_q     <= 1'b0;
            row_ptr_q <= '0;
            window_q  <= '0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            row_ptr_q <= row_ptr_d;
            window_q  <= window_d;
        end
    end

    always_comb begin
        state_d                     = state_q;
        en_line_counter             = 1'b0;
        en_window_start_pos_counter = 1'b0;
        window_valid                = 1'b0;
        done                        = 1'b0;
        busy                        = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                en_line_counter = 1'b1;
                if (cout_addr_generator) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = VALID;
            end
            VALID: begin
                window_valid = 1'b1;
                if (window_ready) begin
                    en_window_start_pos_counter = 1'b1;
                    state_d = window_ld_done ? FINISH : LOAD;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture lags the line enable by one cycle to match the registered memory read.
    always_comb begin
        cap_d     = en_line_counter;
        row_ptr_d = row_ptr_q;
        window_d  = window_q;
        if (cap_q) begin
            for (int unsigned r = 0; r < WIN; r++) begin
                if (row_ptr_q == PTR_W'(r)) window_d[r*ROW_W +: ROW_W] = mem_data;
            end
            row_ptr_d = (row_ptr_q == PTR_LAST) ? '0 : row_ptr_q + PTR_W'(1);
        end
        if (state_d == LOAD && state_q != LOAD) row_ptr_d = '0;
    end

    assign window_data = window_q;

endmodule

// File: tb/tb_window_load_controller.sv
// Directed bench for window_load_controller: 13x13 image, address generator and
// registered memory (data = address) modelled locally.
module tb_window_load_controller;

    localparam int PW   = 8;
    localparam int W    = 4;
    localparam int IMG  = 13;
    localparam int NPOS = IMG - W + 1;
    localparam int RW   = W * PW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               window_ready = 1'b0;
    logic [RW-1:0]      mem_data;
    logic               cout_addr_generator;
    logic               window_ld_done;
    logic               en_line_counter;
    logic               en_window_start_pos_counter;
    logic [W*RW-1:0]    window_data;
    logic               window_valid;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    window_load_controller #(.PIXEL_W(PW), .WIN(W)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .start                       (start),
        .mem_data                    (mem_data),
        .cout_addr_generator         (cout_addr_generator),
        .window_ld_done              (window_ld_done),
        .window_ready                (window_ready),
        .en_line_counter             (en_line_counter),
        .en_window_start_pos_counter (en_window_start_pos_counter),
        .window_data                 (window_data),
        .window_valid                (window_valid),
        .busy                        (busy),
        .done                        (done)
    );

    // Address generator plus registered memory whose word equals its address.
    int lc, pr, pc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lc <= 0; pr <= 0; pc <= 0; mem_data <= '0;
        end else begin
            mem_data <= RW'((pr + lc) * IMG + pc);
            if (en_line_counter) lc <= (lc == W - 1) ? 0 : lc + 1;
            if (en_window_start_pos_counter) begin
                if (pc == NPOS - 1) begin
                    pc <= 0;
                    pr <= (pr == NPOS - 1) ? 0 : pr + 1;
                end else begin
                    pc <= pc + 1;
                end
            end
        end
    end
    assign cout_addr_generator = (lc == W - 1);
    assign window_ld_done      = (pr == NPOS - 1) && (pc == NPOS - 1);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] expw(input int k);
        logic [127:0] w;
        int r, c;
        w = '0;
        r = k / NPOS;
        c = k % NPOS;
        for (int l = 0; l < W; l++) w[l*RW +: RW] = RW'((r + l) * IMG + c);
        return w;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    int k = 0, last_scan_hs = -1, done_cnt = 0, cyc = 0, last_hs_cyc = 0, hs_int = 0;
    logic prev_valid = 1'b0;
    logic [127:0] prev_data = '0, last_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            k = 0;
            prev_valid = 1'b0;
        end else begin
            if (en_window_start_pos_counter)
                check("wspc_outside_hs", {window_valid, window_ready}, 2'b11);
            if (en_line_counter)
                check("line_en_outside_load", {window_valid, done, busy}, 3'b001);
            if (window_valid && prev_valid)
                check("hold", window_data, prev_data);
            if (window_valid && window_ready) begin
                check($sformatf("win%0d", k), window_data, expw(k));
                last_data   = window_data;
                hs_int      = cyc - last_hs_cyc;
                last_hs_cyc = cyc;
                k++;
            end
            if (done) begin
                done_cnt++;
                last_scan_hs = k;
                k = 0;
            end
            prev_valid = window_valid && !window_ready;
            prev_data  = window_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lat, base;
    bit hit;
    logic [127:0] d0;

    initial begin
        // Reset state and no scan on reset release
        tick(); tick();
        check("rst_outs", {en_line_counter, en_window_start_pos_counter, window_valid, busy, done}, 5'b0);
        check("rst_data", window_data, '0);
        rst = 1'b0;
        repeat (3) tick();
        check("no_autostart", busy, 1'b0);

        // Scan 1: ready held high, latency, pacing, ignored mid-scan start
        window_ready = 1'b1;
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            start = 1'b0;
            lat++;
            #1;
            if (window_valid) break;
        end
        check("latency", lat, 6);
        hit = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (k >= 2) begin hit = 1; break; end end
        check("wait_win2", hit, 1'b1);
        check("interval", hs_int, W + 2);
        hit = 0;
        for (int i = 0; i < 500; i++) begin tick(); if (k >= 30) begin hit = 1; break; end end
        check("wait_win30", hit, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        base = done_cnt;
        hit = 0;
        for (int i = 0; i < 2000; i++) begin tick(); if (done_cnt > base) begin hit = 1; break; end end
        check("scan1_done", hit, 1'b1);
        check("scan1_windows", last_scan_hs, 100);
        check("scan1_last_win", last_data, expw(NPOS * NPOS - 1));
        check("done_single", done, 1'b0);
        check("busy_after", busy, 1'b0);
        repeat (3) tick();
        check("done_count", done_cnt - base, 1);

        // Scan 2: hold off the first window, then random backpressure
        window_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (window_valid) begin hit = 1; break; end end
        check("bp_wait_valid", hit, 1'b1);
        d0 = window_data;
        check("bp_first_data", d0, expw(0));
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            check("bp_hold", window_data, d0);
            check("bp_no_en", en_window_start_pos_counter, 1'b0);
        end
        tick();
        window_ready = 1'b1;
        #1;
        check("bp_release_en", en_window_start_pos_counter, 1'b1);
        tick();
        #1;
        check("bp_en_single", en_window_start_pos_counter, 1'b0);
        base = done_cnt;
        hit = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            window_ready = 1'($urandom_range(0, 1));
            if (done_cnt > base) begin hit = 1; break; end
        end
        check("scan2_done", hit, 1'b1);
        check("scan2_windows", last_scan_hs, 100);

        // Scan 3: reset during the 3rd LOAD cycle of window 5, then restart
        window_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (k >= 4) begin hit = 1; break; end end
        check("wait_win5", hit, 1'b1);
        tick(); tick();
        #2;
        check("pre_rst_load", en_line_counter, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {en_line_counter, en_window_start_pos_counter, window_valid, busy, done}, 5'b0);
        check("mid_rst_data", window_data, '0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_idle", busy, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (k >= 1) begin hit = 1; break; end end
        check("restart_hs", hit, 1'b1);
        check("restart_win0", last_data, expw(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
